// File: rtl/detect_capture.sv
// Pre/post-trigger frame capture: keeps a rolling history of the sample stream and, on a
// detector rising edge, freezes one frame and drains it oldest-first over valid/ready.
module detect_capture #(
    parameter int DATA_W   = 8,
    parameter int PRE_LEN  = 8,
    parameter int POST_LEN = 16,
    parameter int MISS_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              detected,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [MISS_W-1:0] missed
);

    localparam int FRAME_LEN = PRE_LEN + POST_LEN;
    localparam int PTR_W     = $clog2(PRE_LEN);
    localparam int POST_AW   = (POST_LEN > 1) ? $clog2(POST_LEN) : 1;
    localparam int CNT_W     = $clog2(POST_LEN + 1);
    localparam int IDX_W     = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic              det_q_reg;
    logic              trig;
    logic [CNT_W-1:0]  cnt_reg;
    logic              last_post;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [IDX_W-1:0]  rd_idx_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic [MISS_W-1:0] missed_reg;

    logic              busy_c;
    logic              hist_we;
    logic              post_we;
    logic [POST_AW-1:0] post_waddr;
    logic              drain_load;
    logic              handshake;
    logic              count_miss;

    logic [IDX_W-1:0]   rd_addr;
    logic [PTR_W-1:0]   hist_rd_ptr;
    logic [POST_AW-1:0] post_raddr;
    logic               rd_is_pre;

    logic [DATA_W-1:0] hist_word [PRE_LEN];
    logic [DATA_W-1:0] post_mem  [POST_LEN];

    // Rising edge of the detector level, judged only on sample strobes.
    assign trig      = enable & detected & ~det_q_reg;
    assign last_post = (cnt_reg == CNT_W'(POST_LEN - 1));
    assign handshake = out_valid_reg & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_ARMED;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARMED: begin
                if (trig) begin
                    state_next = (POST_LEN == 1) ? ST_DRAIN : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (enable && last_post) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (handshake && out_last_reg) begin
                    state_next = ST_ARMED;
                end
            end
            default: state_next = ST_ARMED;
        endcase
    end

    always_comb begin
        busy_c     = (state_reg != ST_ARMED);
        hist_we    = (state_reg == ST_ARMED) && enable && !trig;
        post_we    = ((state_reg == ST_ARMED) && trig) || ((state_reg == ST_CAPTURE) && enable);
        post_waddr = (state_reg == ST_ARMED) ? '0 : POST_AW'(cnt_reg);
        drain_load = (state_reg != ST_DRAIN) && (state_next == ST_DRAIN);
        count_miss = trig && busy_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            det_q_reg <= 1'b0;
        end else if (enable) begin
            det_q_reg <= detected;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if ((state_reg == ST_ARMED) && trig) begin
            cnt_reg <= CNT_W'(1);
        end else if ((state_reg == ST_CAPTURE) && enable) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // History ring only advances while armed, so it is naturally frozen for the whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
        end else if (hist_we) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PRE_LEN; gi++) begin : g_hist
            logic [DATA_W-1:0] slot_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (hist_we && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= sample_in;
                end
            end
            assign hist_word[gi] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (post_we) begin
            post_mem[post_waddr] <= sample_in;
        end
    end

    // Address of the sample to present next: frame index 0 on drain entry, else the successor.
    always_comb begin
        rd_addr     = drain_load ? '0 : (rd_idx_reg + IDX_W'(1));
        rd_is_pre   = (rd_addr < IDX_W'(PRE_LEN));
        hist_rd_ptr = wr_ptr_reg + PTR_W'(rd_addr);
        post_raddr  = POST_AW'(rd_addr - IDX_W'(PRE_LEN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
            rd_idx_reg    <= '0;
        end else if (drain_load) begin
            out_valid_reg <= 1'b1;
            out_last_reg  <= 1'b0;
            out_data_reg  <= rd_is_pre ? hist_word[hist_rd_ptr] : post_mem[post_raddr];
            rd_idx_reg    <= '0;
        end else if (handshake) begin
            if (out_last_reg) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end else begin
                out_data_reg <= rd_is_pre ? hist_word[hist_rd_ptr] : post_mem[post_raddr];
                out_last_reg <= (rd_idx_reg == IDX_W'(FRAME_LEN - 2));
                rd_idx_reg   <= rd_idx_reg + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            missed_reg <= '0;
        end else if (count_miss && (missed_reg != {MISS_W{1'b1}})) begin
            missed_reg <= missed_reg + MISS_W'(1);
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_c;
    assign missed    = missed_reg;

endmodule

// File: tb/tb_detect_capture.sv
// Directed bench for detect_capture: expected frame samples are queued as stimulus is
// driven and popped on every output handshake.
module tb_detect_capture;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] sample_in;
    logic       detected;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic [7:0] missed;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       sb[$];
    int         vectors    = 0;
    int         miscompares = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 1'b0;

    detect_capture #(
        .DATA_W  (8),
        .PRE_LEN (8),
        .POST_LEN(16),
        .MISS_W  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sample_in(sample_in),
        .detected (detected),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .missed   (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] d);
        exp_t e;
        e.d = d;
        e.l = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_range(input int first, input int n);
        for (int k = 0; k < n; k++) push(8'(first + k));
    endtask

    task automatic push_zeros(input int n);
        for (int k = 0; k < n; k++) push(8'h00);
    endtask

    task automatic end_frame();
        sb[sb.size() - 1].l = 1'b1;
    endtask

    // Drive one cycle of inputs and score whatever the DUT presents during it.
    task automatic cycle(input logic en, input logic [7:0] smp, input logic det, input logic rdy);
        exp_t e;
        @(negedge clk);
        enable    = en;
        sample_in = smp;
        detected  = det;
        out_ready = rdy;
        #1;
        if (out_valid) begin
            if (stall_prev) begin
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_last", 32'(out_last), 32'(e.l));
                    $display("beat data=%0d last=%0b", out_data, out_last);
                end
            end
        end
        stall_prev = out_valid & ~rdy;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        enable    = 1'b0;
        sample_in = '0;
        detected  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_missed", 32'(missed), 32'(0));
        check("rst_last", 32'(out_last), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        stall_prev = 1'b0;
    endtask

    task automatic drain(input int budget, input bit toggle);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle(1'b0, 8'h00, 1'b0, toggle ? ~n[0] : 1'b1);
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'(0));
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("idle_valid", 32'(out_valid), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        int posts;
        int v;
        int guard;
        logic en;

        reset     = 1'b1;
        enable    = 1'b0;
        sample_in = '0;
        detected  = 1'b0;
        out_ready = 1'b0;

        // Ramp with a single pulse at sample 20.
        do_reset();
        push_range(12, 24);
        end_frame();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'(i), (i == 20), 1'b1);
            if (i == 35) check("lat_before", 32'(out_valid), 32'(0));
            if (i == 36) check("lat_first", 32'(out_valid), 32'(1));
            if (i == 21) check("busy_capture", 32'(busy), 32'(1));
        end
        drain(100, 1'b0);
        check("t1_missed", 32'(missed), 32'(0));

        // Early trigger: unwritten history slots read as zero.
        do_reset();
        push_zeros(5);
        push_range(0, 3);
        push_range(3, 16);
        end_frame();
        for (int i = 0; i < 19; i++) cycle(1'b1, 8'(i), (i == 3), 1'b1);
        drain(100, 1'b0);

        // Enable gaps during capture, ready toggling during drain.
        do_reset();
        push_range(102, 8);
        push_range(110, 16);
        end_frame();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(100 + i), 1'b0, 1'b1);
        cycle(1'b1, 8'd110, 1'b1, 1'b1);
        posts = 1;
        v     = 111;
        guard = 0;
        while (posts < 16 && guard < 200) begin
            en = 1'($urandom_range(0, 1));
            cycle(en, en ? 8'(v) : 8'hEE, 1'b0, 1'b1);
            if (en) begin
                v++;
                posts++;
            end
            guard++;
        end
        drain(200, 1'b1);

        // Detected level held high gives exactly one frame.
        do_reset();
        push_zeros(8);
        push_range(0, 16);
        end_frame();
        for (int i = 0; i < 50; i++) cycle(1'b1, 8'(i), 1'b1, 1'b1);
        check("held_left", 32'(sb.size()), 32'(0));
        check("held_busy", 32'(busy), 32'(0));
        check("held_missed", 32'(missed), 32'(0));

        // Three pulses while capturing.
        do_reset();
        push_range(50, 8);
        push_range(58, 16);
        end_frame();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(50 + i), 1'b0, 1'b1);
        cycle(1'b1, 8'd58, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++) cycle(1'b1, 8'(58 + k), (k == 2 || k == 4 || k == 6), 1'b1);
        drain(100, 1'b0);
        check("miss3", 32'(missed), 32'(3));

        // History survives the frame; 300 pulses during a stalled drain saturate the counter.
        push_range(50, 8);
        push_range(80, 16);
        end_frame();
        cycle(1'b1, 8'd80, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++) cycle(1'b1, 8'(80 + k), 1'b0, 1'b1);
        for (int p = 0; p < 600; p++) begin
            cycle(1'b1, 8'hAA, (p % 2 == 0), 1'b0);
            if (p == 199) check("miss_mid", 32'(missed), 32'(103));
        end
        check("miss_sat", 32'(missed), 32'(255));
        drain(100, 1'b0);

        // Reset in the middle of a drain, then a fresh frame with zeroed history.
        do_reset();
        push_range(2, 8);
        push_range(10, 16);
        end_frame();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
        cycle(1'b1, 8'd10, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++) cycle(1'b1, 8'(10 + k), 1'b0, 1'b1);
        for (int h = 0; h < 5; h++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("mid_left", 32'(sb.size()), 32'(19));
        do_reset();
        push_zeros(8);
        push_range(40, 16);
        end_frame();
        cycle(1'b1, 8'd40, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++) cycle(1'b1, 8'(40 + k), 1'b0, 1'b1);
        drain(100, 1'b0);

        // Trigger coinciding with the last handshake is missed; the next pulse captures.
        do_reset();
        push_range(60, 8);
        push_range(68, 16);
        end_frame();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(60 + i), 1'b0, 1'b1);
        cycle(1'b1, 8'd68, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++) cycle(1'b1, 8'(68 + k), 1'b0, 1'b1);
        for (int h = 0; h < 24; h++) cycle(1'b1, 8'hCC, (h == 23), 1'b1);
        cycle(1'b1, 8'd90, 1'b0, 1'b1);
        check("edge_missed", 32'(missed), 32'(1));
        check("edge_valid", 32'(out_valid), 32'(0));
        check("edge_left", 32'(sb.size()), 32'(0));
        push_range(61, 7);
        push(8'd90);
        push_range(91, 16);
        end_frame();
        cycle(1'b1, 8'd91, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++) cycle(1'b1, 8'(91 + k), 1'b0, 1'b1);
        drain(100, 1'b0);
        check("edge_missed_end", 32'(missed), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
